// File: rtl/sb_inject_sched.sv
`default_nettype none
// ============================================================================
// Module   : sb_inject_sched
// Brief    : Side-buffer injection scheduler for a 4-slot router stage.
//            Redirected flits wait in a 4-entry FIFO and are re-injected into
//            the lowest-index free slot. Local core flits get the next free
//            slot after that. If the side buffer is blocked for 8 consecutive
//            cycles, one FORCE cycle swaps the buffer head with the east flit.
// Revision : 1.0 - initial release
// ============================================================================
module sb_inject_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] eastad,
    input  logic [10:0] westad,
    input  logic [10:0] northad,
    input  logic [10:0] southad,
    input  logic        e_vld,
    input  logic        w_vld,
    input  logic        n_vld,
    input  logic        s_vld,
    input  logic        sb_push,
    input  logic [10:0] sb_flit,
    input  logic        core_valid,
    input  logic [10:0] core_flit,
    output logic        core_ready,
    output logic [10:0] ead,
    output logic [10:0] wad,
    output logic [10:0] nad,
    output logic [10:0] sad,
    output logic        e_ovld,
    output logic        w_ovld,
    output logic        n_ovld,
    output logic        s_ovld,
    output logic [2:0]  sb_count,
    output logic        sb_full,
    output logic        starve,
    output logic        sb_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_stv_cnt;
    logic [2:0]  w_stv_nxt;

    logic [10:0] r_mem [4];
    logic [1:0]  r_rd_ptr;
    logic [1:0]  r_wr_ptr;
    logic [2:0]  r_count;
    logic        r_ovf;

    logic [10:0] r_ad [4];
    logic [3:0]  r_ovld;

    logic [10:0] w_in_ad [4];
    logic [3:0]  w_in_vld;
    logic [10:0] w_out_ad [4];
    logic [3:0]  w_out_vld;

    logic [2:0]  w_sb_ff;
    logic [2:0]  w_core_ff;
    logic [3:0]  w_occ_after;
    logic        w_sb_has;
    logic        w_inject;
    logic        w_swap;
    logic        w_pop;
    logic        w_ext_acc;
    logic        w_push;
    logic [10:0] w_push_data;
    logic [10:0] w_head;
    logic        w_core_take;
    logic [2:0]  w_count_nxt;

    // Lowest free slot: {found, index}; east has priority.
    function automatic logic [2:0] f_first_free(input logic [3:0] occ);
        casez (occ)
            4'b???0: return 3'b100;
            4'b??01: return 3'b101;
            4'b?011: return 3'b110;
            4'b0111: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    assign w_in_ad[0] = eastad;
    assign w_in_ad[1] = westad;
    assign w_in_ad[2] = northad;
    assign w_in_ad[3] = southad;
    assign w_in_vld   = {s_vld, n_vld, w_vld, e_vld};

    // Head is read from registered storage, so a flit written this cycle
    // cannot be injected before the next one.
    assign w_head      = r_mem[r_rd_ptr];
    assign w_sb_has    = (r_count != 3'd0);
    assign w_sb_ff     = f_first_free(w_in_vld);
    assign w_inject    = w_sb_has && w_sb_ff[2];
    assign w_swap      = w_sb_has && !w_sb_ff[2] && (r_state == ST_FORCE);
    assign w_pop       = w_inject || w_swap;
    assign w_occ_after = w_in_vld | (w_inject ? (4'b0001 << w_sb_ff[1:0]) : 4'b0000);
    assign w_core_ff   = f_first_free(w_occ_after);
    assign core_ready  = (r_state != ST_FORCE) && w_core_ff[2];
    assign w_core_take = core_ready && core_valid;

    // A swap displaces the east flit into the tail and blocks external pushes.
    assign w_ext_acc   = sb_push && !w_swap && ((r_count < 3'd4) || w_pop);
    assign w_push      = w_ext_acc || w_swap;
    assign w_push_data = w_swap ? eastad : sb_flit;
    assign w_count_nxt = r_count + {2'b00, w_push} - {2'b00, w_pop};

    // Build next slot contents: pass-through, then SB head, then core flit.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_out_ad[i]  = w_in_vld[i] ? w_in_ad[i] : 11'h000;
            w_out_vld[i] = w_in_vld[i];
            if ((w_inject && (w_sb_ff[1:0] == 2'(i))) || (w_swap && (i == 0))) begin
                w_out_ad[i]  = w_head;
                w_out_vld[i] = 1'b1;
            end
            if (w_core_take && (w_core_ff[1:0] == 2'(i))) begin
                w_out_ad[i]  = core_flit;
                w_out_vld[i] = 1'b1;
            end
        end
    end

    // Starvation FSM next state and counter.
    always_comb begin
        w_state_nxt = r_state;
        w_stv_nxt   = r_stv_cnt;
        case (r_state)
            ST_IDLE: begin
                w_stv_nxt = 3'd0;
                if (w_count_nxt != 3'd0) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_count_nxt == 3'd0) begin
                    w_state_nxt = ST_IDLE;
                    w_stv_nxt   = 3'd0;
                end else if (w_pop) begin
                    w_stv_nxt   = 3'd0;
                end else if (r_stv_cnt == 3'd7) begin
                    w_state_nxt = ST_FORCE;
                    w_stv_nxt   = 3'd0;
                end else begin
                    w_stv_nxt   = r_stv_cnt + 3'd1;
                end
            end
            ST_FORCE: begin
                w_stv_nxt   = 3'd0;
                w_state_nxt = (w_count_nxt == 3'd0) ? ST_IDLE : ST_WAIT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_stv_nxt   = 3'd0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_stv_cnt <= 3'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_stv_cnt <= w_stv_nxt;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= 2'd0;
            r_wr_ptr <= 2'd0;
            r_count  <= 3'd0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            r_count <= w_count_nxt;
            if (sb_push && !w_ext_acc) r_ovf <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care once pointers reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

    // Registered slot outputs (one-cycle latency).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_ad[i] <= 11'h000;
            r_ovld <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) r_ad[i] <= w_out_ad[i];
            r_ovld <= w_out_vld;
        end
    end

    assign ead      = r_ad[0];
    assign wad      = r_ad[1];
    assign nad      = r_ad[2];
    assign sad      = r_ad[3];
    assign e_ovld   = r_ovld[0];
    assign w_ovld   = r_ovld[1];
    assign n_ovld   = r_ovld[2];
    assign s_ovld   = r_ovld[3];
    assign sb_count = r_count;
    assign sb_full  = (r_count == 3'd4);
    assign starve   = (r_state == ST_FORCE);
    assign sb_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sb_inject_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sb_inject_sched
// Brief    : Self-checking bench for sb_inject_sched: directed scenarios with
//            literal expectations plus randomized traffic against a queue
//            based reference model evaluated every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sb_inject_sched;

    logic        clk;
    logic        rst_n;
    logic [10:0] in_ad [4];
    logic [3:0]  in_vld;
    logic        sb_push;
    logic [10:0] sb_flit;
    logic        core_valid;
    logic [10:0] core_flit;
    logic        core_ready;
    logic [10:0] ead, wad, nad, sad;
    logic        e_ovld, w_ovld, n_ovld, s_ovld;
    logic [2:0]  sb_count;
    logic        sb_full, starve, sb_ovf;

    logic [10:0] d_ad [4];
    logic [3:0]  d_v;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [10:0] q [$];
    int          blocked;
    bit          force_now;
    bit          m_ovf;
    logic [10:0] m_ad [4];
    logic [3:0]  m_v;

    sb_inject_sched dut (
        .clk(clk), .rst_n(rst_n),
        .eastad(in_ad[0]), .westad(in_ad[1]), .northad(in_ad[2]), .southad(in_ad[3]),
        .e_vld(in_vld[0]), .w_vld(in_vld[1]), .n_vld(in_vld[2]), .s_vld(in_vld[3]),
        .sb_push(sb_push), .sb_flit(sb_flit),
        .core_valid(core_valid), .core_flit(core_flit), .core_ready(core_ready),
        .ead(ead), .wad(wad), .nad(nad), .sad(sad),
        .e_ovld(e_ovld), .w_ovld(w_ovld), .n_ovld(n_ovld), .s_ovld(s_ovld),
        .sb_count(sb_count), .sb_full(sb_full), .starve(starve), .sb_ovf(sb_ovf)
    );

    assign d_ad[0] = ead;
    assign d_ad[1] = wad;
    assign d_ad[2] = nad;
    assign d_ad[3] = sad;
    assign d_v     = {s_ovld, n_ovld, w_ovld, e_ovld};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_free(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (!v[i]) return i;
        return -1;
    endfunction

    // Compare DUT against the model, then advance the model by one clock.
    task automatic model_cycle();
        logic [10:0] o_ad [4];
        logic [3:0]  o_v;
        int          fi;
        int          sz;
        bit          popped;
        bit          swap;
        bit          rdy;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) chk("rst_ad", d_ad[i], 0);
            chk("rst_ovld", d_v, 0);
            chk("rst_count", sb_count, 0);
            chk("rst_full", sb_full, 0);
            chk("rst_starve", starve, 0);
            chk("rst_ovf", sb_ovf, 0);
            chk("rst_core_ready", core_ready, in_vld != 4'hF);
            q.delete();
            blocked = 0; force_now = 0; m_ovf = 0; m_v = 0;
            for (int i = 0; i < 4; i++) m_ad[i] = 0;
            return;
        end
        for (int i = 0; i < 4; i++) chk("slot_ad", d_ad[i], m_ad[i]);
        chk("slot_ovld", d_v, m_v);
        chk("sb_count", sb_count, q.size());
        chk("sb_full", sb_full, q.size() == 4);
        chk("starve", starve, force_now);
        chk("sb_ovf", sb_ovf, m_ovf);

        sz = q.size();
        o_v = in_vld;
        for (int i = 0; i < 4; i++) o_ad[i] = in_vld[i] ? in_ad[i] : 11'h000;
        popped = 0; swap = 0;
        if (sz > 0) begin
            fi = first_free(o_v);
            if (fi >= 0) begin
                o_ad[fi] = q[0]; o_v[fi] = 1'b1; popped = 1;
            end else if (force_now) begin
                o_ad[0] = q[0]; swap = 1;
            end
        end
        fi = first_free(o_v);
        rdy = !force_now && (fi >= 0);
        chk("core_ready", core_ready, rdy);
        if (rdy && core_valid) begin
            o_ad[fi] = core_flit; o_v[fi] = 1'b1;
        end

        if (popped || swap) void'(q.pop_front());
        if (swap) q.push_back(in_ad[0]);
        if (sb_push) begin
            if (!swap && (sz < 4 || popped)) q.push_back(sb_flit);
            else m_ovf = 1;
        end

        if (force_now) begin
            force_now = 0; blocked = 0;
        end else if (sz > 0 && !popped) begin
            blocked++;
            if (blocked == 8) begin
                force_now = 1; blocked = 0;
            end
        end else begin
            blocked = 0;
        end

        for (int i = 0; i < 4; i++) m_ad[i] = o_ad[i];
        m_v = o_v;
    endtask

    // Model check at the falling edge, then return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] v, input logic p, input logic [10:0] f,
                          input logic cv, input logic [10:0] cf);
        in_vld = v; sb_push = p; sb_flit = f; core_valid = cv; core_flit = cf;
        for (int i = 0; i < 4; i++) in_ad[i] = 11'h100 + 11'(i);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(4'h0, 1'b0, 11'h0, 1'b0, 11'h0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(4'h0, 1'b0, 11'h0, 1'b0, 11'h0);
        q.delete();
        blocked = 0; force_now = 0; m_ovf = 0; m_v = 0;
        for (int i = 0; i < 4; i++) m_ad[i] = 0;

        // Core injection into empty slots
        do_reset();
        chk("lit_reset_count", sb_count, 0);
        set_in(4'h0, 1'b0, 11'h0, 1'b1, 11'h02C);
        #1;
        chk("lit_core_ready", core_ready, 1);
        tick();
        chk("lit_core_ead", ead, 11'h02C);
        chk("lit_core_ovld", d_v, 4'b0001);

        // Pushed flit injected one cycle later into west
        do_reset();
        set_in(4'b0001, 1'b1, 11'h005, 1'b0, 11'h0);
        tick();
        chk("lit_push_count", sb_count, 1);
        set_in(4'b0001, 1'b0, 11'h0, 1'b0, 11'h0);
        tick();
        chk("lit_west_wad", wad, 11'h005);
        chk("lit_west_ovld", w_ovld, 1);
        chk("lit_west_count", sb_count, 0);

        // Starvation and FORCE swap
        do_reset();
        set_in(4'hF, 1'b1, 11'h123, 1'b0, 11'h0);
        tick();
        set_in(4'hF, 1'b0, 11'h0, 1'b0, 11'h0);
        repeat (7) tick();
        chk("lit_starve_before", starve, 0);
        tick();
        chk("lit_starve", starve, 1);
        chk("lit_starve_count", sb_count, 1);
        in_ad[0] = 11'h421;
        #1;
        chk("lit_force_core_ready", core_ready, 0);
        tick();
        chk("lit_swap_ead", ead, 11'h123);
        chk("lit_swap_ovld", e_ovld, 1);
        chk("lit_swap_count", sb_count, 1);
        chk("lit_swap_starve", starve, 0);
        set_in(4'h0, 1'b0, 11'h0, 1'b0, 11'h0);
        tick();
        chk("lit_displaced_ead", ead, 11'h421);
        chk("lit_displaced_count", sb_count, 0);

        // Overflow and push+pop at full
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_in(4'hF, 1'b1, 11'h0A0 + 11'(k), 1'b0, 11'h0);
            tick();
        end
        chk("lit_full_count", sb_count, 4);
        chk("lit_full_flag", sb_full, 1);
        chk("lit_ovf_clear", sb_ovf, 0);
        set_in(4'hF, 1'b1, 11'h0EE, 1'b0, 11'h0);
        tick();
        chk("lit_ovf_set", sb_ovf, 1);
        chk("lit_ovf_count", sb_count, 4);
        set_in(4'h0, 1'b1, 11'h0F5, 1'b0, 11'h0);
        tick();
        chk("lit_pushpop_ead", ead, 11'h0A0);
        chk("lit_pushpop_count", sb_count, 4);
        set_in(4'h0, 1'b0, 11'h0, 1'b0, 11'h0);
        tick();
        chk("lit_order1", ead, 11'h0A1);
        tick();
        chk("lit_order2", ead, 11'h0A2);
        tick();
        chk("lit_order3", ead, 11'h0A3);
        tick();
        chk("lit_order4", ead, 11'h0F5);
        chk("lit_ovf_sticky", sb_ovf, 1);

        // SB head takes the only free slot, core must wait
        do_reset();
        set_in(4'hF, 1'b1, 11'h0AA, 1'b0, 11'h0);
        tick();
        set_in(4'b1101, 1'b0, 11'h0, 1'b1, 11'h3FF);
        #1;
        chk("lit_core_blocked", core_ready, 0);
        tick();
        chk("lit_sb_west", wad, 11'h0AA);
        chk("lit_sb_west_ovld", w_ovld, 1);

        // Asynchronous reset in the middle of FORCE
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_in(4'hF, 1'b1, 11'h111 + 11'(k), 1'b0, 11'h0);
            tick();
        end
        set_in(4'hF, 1'b0, 11'h0, 1'b0, 11'h0);
        repeat (6) tick();
        chk("lit_force3_starve", starve, 1);
        chk("lit_force3_count", sb_count, 3);
        rst_n = 1'b0;
        #1;
        chk("lit_async_starve", starve, 0);
        chk("lit_async_count", sb_count, 0);
        chk("lit_async_ovld", d_v, 0);
        chk("lit_async_ead", ead, 0);
        tick();
        rst_n = 1'b1;

        // Randomized traffic; alternating busy phases provoke FORCE
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < 4; i++) begin
                in_ad[i] = 11'($urandom_range(0, 2047));
                if (((c / 64) % 2) == 1) in_vld[i] = ($urandom_range(0, 9) != 0);
                else                     in_vld[i] = ($urandom_range(0, 3) != 0);
            end
            sb_push    = ($urandom_range(0, 1) == 1);
            sb_flit    = 11'($urandom_range(0, 2047));
            core_valid = ($urandom_range(0, 1) == 1);
            core_flit  = 11'($urandom_range(0, 2047));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
